lr_predictor: RTL
=================

Name: lr_predictor

Overview:
- Downstream consumer of Linear_Regression.
- Captures the fitted coefficients B1, B0 and the MSE once a fit completes. Coefficient capture is triggered by `coef_load`, which is driven from the falling edge of the regressor's busy.
- Then streams (X, Y) sample pairs through a 3-stage valid/ready pipeline.
- Per sample it produces the prediction Y_hat = B1*X + B0, the residual Y - Y_hat, and an outlier flag (residual² > THRESH × MSE).

Parameters:
- THRESH, 9, integer outlier multiplier applied to MSE (unsigned, 1..255).
- FRAC, 16, fractional bits of B1/B0/MSE fixed-point format; fixed at 16, other values unsupported.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- coef_load  in  1  one-cycle strobe: capture B1, B0, MSE
- B1  in  32  slope, signed Q16.16
- B0  in  32  intercept, signed Q16.16
- MSE  in  32  mean squared error, unsigned Q16.16
- in_valid  in  1  X/Y sample valid
- in_ready  out  1  block accepts sample this cycle
- X  in  16  signed integer sample
- Y  in  16  signed integer observed value
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- Y_hat  out  16  signed predicted value, rounded and saturated
- resid  out  17  signed Y - Y_hat
- outlier  out  1  resid² > THRESH*MSE
- coef_valid  out  1  active coefficients present

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE; all pipeline valids 0.
  - out_valid=0, Y_hat=0, resid=0, outlier=0, coef_valid=0, in_ready=0.
  - Active and shadow coefficients cleared; pending flag cleared.
  - Reset mid-stream discards in-flight samples, no output emitted.
- States:
  - IDLE: no coefficients; in_ready=0. coef_load → capture directly into active regs → RUN.
  - RUN: coef_valid=1.
    - coef_load with pipeline empty and no accept this cycle → active regs updated next edge, stay RUN.
    - Otherwise → capture into shadow regs, go to DRAIN.
  - DRAIN: in_ready=0. When all 3 stage valids are 0 → copy shadow to active → RUN.
    - Further coef_load in DRAIN overwrites shadow (last wins).
- Handshake:
  - advance = !out_valid | out_ready; the whole pipeline stalls when advance==0.
  - in_ready = (state==RUN) & advance & !coef_load.
  - A sample is accepted on an edge with in_valid & in_ready.
  - Outputs stay stable while out_valid & !out_ready.
- Latency: 3 cycles from accept to out_valid with no stall; throughput 1 sample/cycle.
- Stage 1: P = B1 × X, signed 48-bit; register Y.
- Stage 2: S = P + sign-extended B0 (48-bit).
  - Round half toward +inf: R = (S + 2^15) >>> 16.
  - Saturate R to [-32768, 32767] → Y_hat.
  - resid = Y - Y_hat, 17-bit signed, no overflow possible.
- Stage 3: outlier = (resid² << 16) > THRESH × MSE.
  - Unsigned compare at 50 bits; strict greater-than.
  - MSE==0 → outlier=1 for any nonzero resid, 0 for zero resid.
- Coefficients used by a sample are those active at its stage-1 entry; DRAIN guarantees no mixing.
- coef_load simultaneous with in_valid: load wins, sample not accepted.

Test Plan:
- Reset, then in_valid=1 with no coef_load → in_ready stays 0, out_valid stays 0 for 20 cycles.
- Load B1=0x00020000, B0=0x00018000, MSE=0x00040000, THRESH=9:
  - X=10, Y=22 → Y_hat=22, resid=0, outlier=0, out_valid exactly 3 cycles after accept.
  - X=-10, Y=-18 → Y_hat=-18 (rounding of -18.5), resid=0.
- Same coefficients, X=10:
  - Y=30 → resid=8, outlier=1 (64>36).
  - Y=28 → resid=6, outlier=0 (36 not >36, boundary).
- B1=0x7FFF0000, B0=0, X=100 → Y_hat=32767 (saturate). X=-100 → Y_hat=-32768.
- Stream 16 samples back-to-back with out_ready toggling 1,0,0,1…:
  - No sample lost or duplicated.
  - Outputs held during stalls; order preserved.
- Mid-stream coef_load with B1=0x00010000, B0=0 while 3 samples in flight:
  - in_ready drops; the 3 in-flight samples complete with the old coefficients.
  - The next sample (X=5) gives Y_hat=5.
  - Assert rst=0 during a later stream → out_valid=0 the next cycle, coef_valid=0.

Source files
------------

// File: rtl/lr_predictor.sv
// lr_predictor
// Consumes the result of a Linear_Regression fit and evaluates it over a
// stream of samples. The fitted coefficients (B1, B0 and the MSE) are captured
// on coef_load. (X, Y) pairs then flow through a three-stage valid/ready
// pipeline. Each result carries the prediction Y_hat = B1*X + B0, which is
// rounded and saturated to 16 bits, the residual Y - Y_hat, and an outlier flag
// that is set when residual^2 > THRESH * MSE.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   coef_load   one-cycle strobe that captures B1 / B0 / MSE
//   B1, B0      slope and intercept, signed Q16.16
//   MSE         mean squared error, unsigned Q16.16
//   in_valid    X/Y sample valid
//   in_ready    sample is accepted this cycle when in_valid is also high
//   X, Y        signed integer sample and observed value
//   out_valid   result valid; the result holds until out_ready
//   out_ready   downstream accepts the result
//   Y_hat       signed prediction, rounded half toward +inf, saturated
//   resid       signed Y - Y_hat
//   outlier     resid^2 > THRESH * MSE
//   coef_valid  a set of active coefficients is present
//
// Parameters
//   THRESH      outlier multiplier applied to MSE (1..255)
//   FRAC        number of fractional bits in B1/B0/MSE; only 16 is supported
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | no coefficients yet, input closed
// RUN   | active coefficients valid, samples accepted
// DRAIN | new coefficients wait in shadow regs until the pipeline is empty

module lr_predictor #(
    parameter int THRESH = 9,
    parameter int FRAC   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coef_load,
    input  logic [31:0]        B1,
    input  logic [31:0]        B0,
    input  logic [31:0]        MSE,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] X,
    input  logic signed [15:0] Y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] Y_hat,
    output logic signed [16:0] resid,
    output logic               outlier,
    output logic               coef_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic signed [47:0] RND     = 48'sh1 << (FRAC - 1);
    localparam logic signed [47:0] SAT_MAX = 48'sd32767;
    localparam logic signed [47:0] SAT_MIN = -48'sd32768;
    localparam logic [7:0]         THRESH_W = 8'(THRESH);

    state_t state, state_nxt;

    logic [31:0] b1_act, b0_act, mse_act;
    logic [31:0] b1_sh,  b0_sh,  mse_sh;

    logic v1, v2, v3;
    logic advance, accept, pipe_empty;
    logic load_act_in, load_act_sh, load_sh;

    // Stage registers.
    logic signed [47:0] p1;
    logic signed [15:0] y1;
    logic signed [15:0] yhat2;
    logic signed [16:0] resid2;

    // Stage combinational results.
    logic signed [47:0] prod;
    logic signed [47:0] b0_ext;
    logic signed [47:0] sum2;
    logic signed [47:0] rnd2;
    logic signed [15:0] yhat_sat;
    logic signed [16:0] resid_nxt;
    logic [16:0]        mag;
    logic [33:0]        sq;
    logic [49:0]        lhs, rhs;
    logic               outlier_nxt;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign advance    = !v3 || out_ready;
    assign pipe_empty = !(v1 || v2 || v3);
    assign in_ready   = (state == RUN) && advance && !coef_load;
    assign accept     = in_valid && in_ready;
    assign out_valid  = v3;
    assign coef_valid = (state != IDLE);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_act_in = 1'b0;
        load_act_sh = 1'b0;
        load_sh     = 1'b0;
        case (state)
            IDLE: begin
                if (coef_load) begin
                    load_act_in = 1'b1;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                if (coef_load) begin
                    // Nothing in flight: the new set can go straight in.
                    if (pipe_empty && !accept) begin
                        load_act_in = 1'b1;
                    end else begin
                        load_sh   = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    // A load arriving on the same cycle is newer than the shadow.
                    if (coef_load) begin
                        load_act_in = 1'b1;
                    end else begin
                        load_act_sh = 1'b1;
                    end
                    state_nxt = RUN;
                end else if (coef_load) begin
                    load_sh = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Coefficient registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            b1_act  <= '0;
            b0_act  <= '0;
            mse_act <= '0;
            b1_sh   <= '0;
            b0_sh   <= '0;
            mse_sh  <= '0;
        end else begin
            if (load_act_in) begin
                b1_act  <= B1;
                b0_act  <= B0;
                mse_act <= MSE;
            end else if (load_act_sh) begin
                b1_act  <= b1_sh;
                b0_act  <= b0_sh;
                mse_act <= mse_sh;
            end
            if (load_sh) begin
                b1_sh  <= B1;
                b0_sh  <= B0;
                mse_sh <= MSE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // The active coefficients cannot change while a sample is in flight, so
    // stages 2 and 3 can read b0_act and mse_act directly.
    assign prod = $signed({{16{b1_act[31]}}, b1_act}) * $signed({{32{X[15]}}, X});

    assign b0_ext = $signed({{16{b0_act[31]}}, b0_act});
    assign sum2   = p1 + b0_ext + RND;
    assign rnd2   = sum2 >>> FRAC;

    always_comb begin
        yhat_sat = rnd2[15:0];
        if (rnd2 > SAT_MAX) begin
            yhat_sat = 16'sh7FFF;
        end else if (rnd2 < SAT_MIN) begin
            yhat_sat = 16'sh8000;
        end
    end

    assign resid_nxt = {y1[15], y1} - {yhat_sat[15], yhat_sat};

    // resid is an integer and MSE is Q16.16, so resid^2 is scaled up by FRAC
    // before the compare. The product of |resid| with itself fits in 34 bits.
    assign mag         = resid2[16] ? (17'd0 - resid2) : resid2;
    assign sq          = 34'(mag) * 34'(mag);
    assign lhs         = 50'(sq) << FRAC;
    assign rhs         = 50'(THRESH_W) * 50'(mse_act);
    assign outlier_nxt = lhs > rhs;

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            p1      <= '0;
            y1      <= '0;
            yhat2   <= '0;
            resid2  <= '0;
            Y_hat   <= '0;
            resid   <= '0;
            outlier <= 1'b0;
        end else if (advance) begin
            v1 <= accept;
            v2 <= v1;
            v3 <= v2;
            if (accept) begin
                p1 <= prod;
                y1 <= Y;
            end
            if (v1) begin
                yhat2  <= yhat_sat;
                resid2 <= resid_nxt;
            end
            if (v2) begin
                Y_hat   <= yhat2;
                resid   <= resid2;
                outlier <= outlier_nxt;
            end
        end
    end

endmodule
